grid_board_ctrl: RTL and testbench
==================================

# grid_board_ctrl

Parametrised game-board store with move arbitration for the grid-game datapath. It holds a ROWS×COLS array of cell markers and accepts move requests through a valid/ready handshake. Each request is checked for range, turn order and occupancy before the cell is written. It tracks whose turn it is and how many moves have been played, and clears the board with a row-per-cycle sweep. Rule and display logic read the board through `board_flat` or the random-access read port.

## Interface
Parameters:
- `ROWS`, default 5: board rows, at least 2.
- `COLS`, default 5: board columns, at least 2.
- `PLAYERS`, default 2: number of players, at least 2. Marker 0 means empty; markers 1..PLAYERS are players.
- `CW`, default `$clog2(PLAYERS+1)`: cell and player-id width.
- `RW`, default `$clog2(ROWS)`: row index width.
- `KW`, default `$clog2(COLS)`: column index width.
- `NW`, default `$clog2(ROWS*COLS+1)`: move-counter width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear_req` in 1: start a board clear sweep.
- `move_valid` in 1: move request present.
- `move_player` in CW: player placing the marker.
- `move_row` in RW: target row.
- `move_col` in KW: target column.
- `move_ready` out 1: block can accept a move this cycle.
- `move_ack` out 1: one-cycle pulse, move accepted and cell written.
- `move_err` out 1: one-cycle pulse, move rejected.
- `err_code` out 2: reason for the rejection; valid while `move_err` is high.
- `turn` out CW: player expected to move next.
- `move_count` out NW: number of accepted moves since the last reset or clear.
- `board_full` out 1: `move_count == ROWS*COLS`.
- `busy` out 1: clear sweep in progress.
- `rd_row` in RW, `rd_col` in KW: read address.
- `rd_cell` out CW: combinational read of cell[rd_row][rd_col]; reads 0 when the address is out of range.
- `board_flat` out ROWS*COLS*CW: all cells. Cell (r,c) is at bits [(r*COLS+c)*CW +: CW].

## Operation
- The controller has two states: IDLE and CLEAR.
- Leaving reset: state IDLE, every cell 0, `turn`=1, `move_count`=0. `move_ack`, `move_err`, `err_code` and `busy` are 0; `move_ready` is 1.
- `move_ready` = (state == IDLE). It is registered-state only and has no input dependence.
- Move evaluation happens at an edge where `move_valid` and `move_ready` are both 1. The first matching check, in this priority order, decides the result:
  - `clear_req`=1 at the same edge: reject with code 0 (preempted).
  - `move_row >= ROWS` or `move_col >= COLS`: reject with code 1 (range).
  - `move_player != turn`: reject with code 2 (turn). This includes player 0.
  - Target cell nonzero: reject with code 3 (occupied).
  - Otherwise accept.
- On accept:
  - Write `move_player` into the cell.
  - `move_count` increments.
  - `turn` advances to turn+1, wrapping from PLAYERS back to 1.
- On reject, no state changes except the `move_err`/`err_code` outputs.
- `clear_req` is honoured in IDLE. At that edge:
  - Go to CLEAR.
  - Row pointer is set to 0.
  - `turn` is set to 1 and `move_count` to 0.
- In CLEAR, each cycle zeroes every cell of row `ptr` and then increments `ptr`. After row ROWS-1 is zeroed, return to IDLE.
- `clear_req` during CLEAR is ignored; the sweep is not restarted.
- `move_valid` during CLEAR gets no response: no ack and no err. The requester holds the request until `move_ready` is 1.
- Cells are written only by an accepted move or by the sweep. No other path modifies them.

## Timing
- Move latency: the cell write, `move_count` and `turn` updates all occur at the accepting edge. `move_ack` is high for exactly the cycle following that edge.
- Rejection: `move_err` and `err_code` are registered and high for the one cycle following the evaluating edge. `err_code` returns to 0 afterwards.
- Back-to-back moves, one per cycle, are supported. The occupancy check sees every earlier accepted write, so a second move to the same cell on the next edge gets code 3.
- `board_full` and `rd_cell` are combinational from state; `rd_cell` reflects a write in the cycle after the writing edge.
- A clear takes exactly ROWS cycles. `busy` and `!move_ready` hold for those ROWS cycles, starting the cycle after the `clear_req` edge.
- Asynchronous reset at any point, including mid-sweep or on the same edge as a move, forces the reset values immediately. No pending ack or err survives reset.
- `move_count` saturates by construction: once the board is full, every further move is rejected with code 3 or earlier.

## Test plan
- Reset, then player 1 moves to (2,3) -> next cycle `move_ack`=1; `board_flat` cell 13 = 1; `turn`=2; `move_count`=1.
- Player 2 moves to (2,3), then player 1 moves out of turn, then player 2 moves to (5,0) -> `err_code` 3, 2 and 1 respectively; board unchanged; `turn` stays 2.
- Fill all 25 cells alternating players 1/2 -> `board_full`=1 after the 25th ack; the 26th move gets `err_code`=3.
- Partial board, then `clear_req` -> `busy` high for 5 cycles; a move held during the sweep gets no response and is accepted the cycle after `busy` falls; the other cells read 0.
- Same-edge `clear_req` and a valid move -> `move_err` with `err_code`=0 and the sweep starts; `clear_req` re-asserted mid-sweep does not extend `busy` beyond 5 cycles.
- Build with PLAYERS=3, ROWS=4, COLS=6 -> turn cycles 1,2,3,1; `rst_n` pulsed low mid-sweep clears the board asynchronously, sets `turn`=1 and drops `busy` to 0.

Source files
------------

// File: rtl/grid_board_ctrl.sv
// ---------------------------------------------------------------------------
// grid_board_ctrl
//
// Purpose:
//   Board store for the grid-game datapath. It holds a ROWS x COLS array of
//   cell markers: 0 means empty, and 1..PLAYERS is the player who owns the
//   cell. Move requests arrive on a valid/ready handshake. Each move is
//   checked for range, turn order and occupancy before its cell is written.
//   The block tracks whose turn it is and how many moves have been played.
//   A clear request wipes the board one row per cycle.
//
// Ports:
//   clk, rst_n           single clock; asynchronous active-low reset
//   clear_req            start a board clear sweep (ignored while sweeping)
//   move_valid           move request present
//   move_player          player placing the marker
//   move_row, move_col   target cell
//   move_ready           high while idle; a move can be evaluated this cycle
//   move_ack             one-cycle pulse after an accepted move
//   move_err             one-cycle pulse after a rejected move
//   err_code             rejection reason (0 preempted, 1 range, 2 turn,
//                        3 occupied); zero whenever move_err is low
//   turn                 player expected to move next
//   move_count           accepted moves since reset or the last clear
//   board_full           every cell has been played
//   busy                 clear sweep in progress
//   rd_row, rd_col       random-access read address
//   rd_cell              cell at the read address; 0 when out of range
//   board_flat           all cells; cell (r,c) at [(r*COLS+c)*CW +: CW]
// ---------------------------------------------------------------------------
module grid_board_ctrl #(
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int PLAYERS = 2,
  parameter int CW      = $clog2(PLAYERS + 1),
  parameter int RW      = $clog2(ROWS),
  parameter int KW      = $clog2(COLS),
  parameter int NW      = $clog2(ROWS * COLS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  input  logic                    move_valid,
  input  logic [CW-1:0]           move_player,
  input  logic [RW-1:0]           move_row,
  input  logic [KW-1:0]           move_col,
  output logic                    move_ready,
  output logic                    move_ack,
  output logic                    move_err,
  output logic [1:0]              err_code,
  output logic [CW-1:0]           turn,
  output logic [NW-1:0]           move_count,
  output logic                    board_full,
  output logic                    busy,
  input  logic [RW-1:0]           rd_row,
  input  logic [KW-1:0]           rd_col,
  output logic [CW-1:0]           rd_cell,
  output logic [ROWS*COLS*CW-1:0] board_flat
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // The limits get one extra bit so that an index can be compared with
  // ROWS or COLS even when the count is a power of two.
  localparam logic [RW:0]   ROW_LIMIT   = (RW + 1)'(ROWS);
  localparam logic [KW:0]   COL_LIMIT   = (KW + 1)'(COLS);
  localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
  localparam logic [CW-1:0] FIRST_PLAYER = CW'(1);
  localparam logic [CW-1:0] LAST_PLAYER = CW'(PLAYERS);
  localparam logic [NW-1:0] CELL_TOTAL  = NW'(ROWS * COLS);

  localparam logic [1:0] ERR_PREEMPT  = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_TURN     = 2'd2;
  localparam logic [1:0] ERR_OCCUPIED = 2'd3;

  logic [0:0]    state;
  logic [RW-1:0] ptr;

  // The packed layout places cell (0,0) in the least significant bits and
  // row-major order above it, so board_flat is a direct copy of the store.
  logic [ROWS-1:0][COLS-1:0][CW-1:0] cells;

  logic          move_in_range;
  logic          rd_in_range;
  logic [CW-1:0] target_cell;
  logic          evaluate;
  logic          accept_ok;
  logic          accept_move;
  logic [1:0]    reject_code;
  logic [CW-1:0] next_turn;

  assign move_in_range = ({1'b0, move_row} < ROW_LIMIT) && ({1'b0, move_col} < COL_LIMIT);
  assign rd_in_range   = ({1'b0, rd_row} < ROW_LIMIT) && ({1'b0, rd_col} < COL_LIMIT);

  // Occupancy lookup for the requested cell. An out-of-range address never
  // reaches the occupancy check, so it reads as empty instead of indexing
  // past the array.
  always_comb begin
    target_cell = '0;
    if (move_in_range) begin
      target_cell = cells[move_row][move_col];
    end
  end

  // Checks in priority order: the first one that fails sets the reject
  // code. A move offered together with a clear request loses to the clear.
  always_comb begin
    accept_ok   = 1'b0;
    reject_code = ERR_PREEMPT;
    if (clear_req) begin
      reject_code = ERR_PREEMPT;
    end else if (!move_in_range) begin
      reject_code = ERR_RANGE;
    end else if (move_player != turn) begin
      reject_code = ERR_TURN;
    end else if (target_cell != '0) begin
      reject_code = ERR_OCCUPIED;
    end else begin
      accept_ok = 1'b1;
    end
  end

  assign evaluate    = move_valid && (state == ST_IDLE);
  assign accept_move = evaluate && accept_ok;
  assign next_turn   = (turn == LAST_PLAYER) ? FIRST_PLAYER : turn + CW'(1);

  // Control state: the IDLE/CLEAR sequencing, the sweep row pointer, turn
  // and move bookkeeping, and the registered ack/err pulses. The pulses are
  // recomputed every cycle, so each one lasts exactly one cycle. A clear
  // honoured in IDLE resets the bookkeeping at once, while the cells are
  // wiped over the following ROWS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      turn       <= FIRST_PLAYER;
      move_count <= '0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      move_ack <= accept_move;
      move_err <= evaluate && !accept_ok;
      err_code <= (evaluate && !accept_ok) ? reject_code : 2'd0;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            turn       <= FIRST_PLAYER;
            move_count <= '0;
          end else if (accept_move) begin
            move_count <= move_count + NW'(1);
            turn       <= next_turn;
          end
        end
        ST_CLEAR: begin
          ptr <= ptr + RW'(1);
          if (ptr == LAST_ROW) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Cell store: only the sweep and an accepted move ever write it. While
  // the sweep runs no move can be accepted, so the two writes never meet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells <= '0;
    end else if (state == ST_CLEAR) begin
      cells[ptr] <= '0;
    end else if (accept_move) begin
      cells[move_row][move_col] <= move_player;
    end
  end

  // Random-access read. An out-of-range address reads as empty.
  always_comb begin
    rd_cell = '0;
    if (rd_in_range) begin
      rd_cell = cells[rd_row][rd_col];
    end
  end

  assign move_ready = (state == ST_IDLE);
  assign busy       = (state == ST_CLEAR);
  assign board_full = (move_count == CELL_TOTAL);
  assign board_flat = cells;

endmodule

// File: tb/tb_grid_board_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grid_board_ctrl
//
// Self-checking bench for grid_board_ctrl. The default 5x5, two-player build
// is compared every cycle against a cell-array model of the game rules.
// Hand-computed literal checks pin that model. A second 4x6, three-player
// build is exercised with directed literal checks, which cover turn cycling
// and an asynchronous reset that lands in the middle of a sweep.
// ---------------------------------------------------------------------------
module tb_grid_board_ctrl;

  localparam int ROWS    = 5;
  localparam int COLS    = 5;
  localparam int PLAYERS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic        rst_n;
  logic        clear_req;
  logic        move_valid;
  logic [1:0]  move_player;
  logic [2:0]  move_row;
  logic [2:0]  move_col;
  logic        move_ready;
  logic        move_ack;
  logic        move_err;
  logic [1:0]  err_code;
  logic [1:0]  turn;
  logic [4:0]  move_count;
  logic        board_full;
  logic        busy;
  logic [2:0]  rd_row;
  logic [2:0]  rd_col;
  logic [1:0]  rd_cell;
  logic [49:0] board_flat;

  // 4x6, three-player build
  logic        rst2_n;
  logic        clr2;
  logic        v2;
  logic [1:0]  p2;
  logic [1:0]  r2;
  logic [2:0]  c2;
  logic        ready2;
  logic        ack2;
  logic        err2;
  logic [1:0]  code2;
  logic [1:0]  turn2;
  logic [4:0]  count2;
  logic        full2;
  logic        busy2;
  logic [1:0]  rdr2;
  logic [2:0]  rdc2;
  logic [1:0]  rdcell2;
  logic [47:0] flat2;

  grid_board_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .move_valid(move_valid),
    .move_player(move_player), .move_row(move_row), .move_col(move_col),
    .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
    .err_code(err_code), .turn(turn), .move_count(move_count),
    .board_full(board_full), .busy(busy), .rd_row(rd_row), .rd_col(rd_col),
    .rd_cell(rd_cell), .board_flat(board_flat)
  );

  grid_board_ctrl #(.ROWS(4), .COLS(6), .PLAYERS(3)) dut2 (
    .clk(clk), .rst_n(rst2_n), .clear_req(clr2), .move_valid(v2),
    .move_player(p2), .move_row(r2), .move_col(c2),
    .move_ready(ready2), .move_ack(ack2), .move_err(err2),
    .err_code(code2), .turn(turn2), .move_count(count2),
    .board_full(full2), .busy(busy2), .rd_row(rdr2), .rd_col(rdc2),
    .rd_cell(rdcell2), .board_flat(flat2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rd_seq   = 0;

  // Rules model for the default build
  int mdl_board [ROWS][COLS];
  int mdl_turn;
  int mdl_count;
  int mdl_left;
  int mdl_ack;
  int mdl_err;
  int mdl_code;

  // Directed moves for the 4x6 build: player, row, col; expected turn after
  int mv2 [5][3] = '{'{1, 0, 0}, '{2, 0, 1}, '{3, 0, 2}, '{1, 1, 0}, '{2, 3, 5}};
  int exp_turn2 [5] = '{2, 3, 1, 2, 3};

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] p, input logic [2:0] r,
                               input logic [2:0] c, input logic clr);
    @(negedge clk);
    move_valid  = v;
    move_player = p;
    move_row    = r;
    move_col    = c;
    clear_req   = clr;
    rd_row      = 3'(rd_seq % 8);
    rd_col      = 3'((rd_seq / 8) % 8);
    rd_seq      = rd_seq + 3;
  endtask

  // Model update: one game-rule step per rising edge, wiped by reset.
  task automatic updateModel();
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mdl_board[r][c] = 0;
      mdl_turn  = 1;
      mdl_count = 0;
      mdl_left  = 0;
      mdl_ack   = 0;
      mdl_err   = 0;
      mdl_code  = 0;
    end else begin
      mdl_ack  = 0;
      mdl_err  = 0;
      mdl_code = 0;
      if (mdl_left > 0) begin
        for (int c = 0; c < COLS; c++)
          mdl_board[ROWS - mdl_left][c] = 0;
        mdl_left--;
      end else begin
        if (move_valid) begin
          if (clear_req) begin
            mdl_err = 1; mdl_code = 0;
          end else if (int'(move_row) >= ROWS || int'(move_col) >= COLS) begin
            mdl_err = 1; mdl_code = 1;
          end else if (int'(move_player) != mdl_turn) begin
            mdl_err = 1; mdl_code = 2;
          end else if (mdl_board[move_row][move_col] != 0) begin
            mdl_err = 1; mdl_code = 3;
          end else begin
            mdl_board[move_row][move_col] = int'(move_player);
            mdl_count++;
            mdl_turn = (mdl_turn % PLAYERS) + 1;
            mdl_ack  = 1;
          end
        end
        if (clear_req) begin
          mdl_left  = ROWS;
          mdl_turn  = 1;
          mdl_count = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      updateModel();
    end
  end

  // Every-cycle comparison of the default build against the model.
  initial begin
    logic [49:0] exp_flat;
    int          exp_rd;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        exp_flat = '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            exp_flat[(r * COLS + c) * 2 +: 2] = 2'(mdl_board[r][c]);
        exp_rd = 0;
        if (int'(rd_row) < ROWS && int'(rd_col) < COLS) exp_rd = mdl_board[rd_row][rd_col];
        checkOutput("cmp_ack", 64'(move_ack), 64'(mdl_ack));
        checkOutput("cmp_err", 64'(move_err), 64'(mdl_err));
        checkOutput("cmp_code", 64'(err_code), 64'(mdl_code));
        checkOutput("cmp_turn", 64'(turn), 64'(mdl_turn));
        checkOutput("cmp_count", 64'(move_count), 64'(mdl_count));
        checkOutput("cmp_full", 64'(board_full), 64'(mdl_count == ROWS * COLS));
        checkOutput("cmp_busy", 64'(busy), 64'(mdl_left > 0));
        checkOutput("cmp_ready", 64'(move_ready), 64'(mdl_left == 0));
        checkOutput("cmp_rd_cell", 64'(rd_cell), 64'(exp_rd));
        checkOutput("cmp_board", 64'(board_flat), 64'(exp_flat));
      end
    end
  end

  initial begin
    int first_ack;
    int busy_cnt;
    logic [49:0] bf;

    rst_n = 1'b0; rst2_n = 1'b0;
    move_valid = 1'b0; move_player = '0; move_row = '0; move_col = '0; clear_req = 1'b0;
    rd_row = '0; rd_col = '0;
    clr2 = 1'b0; v2 = 1'b0; p2 = '0; r2 = '0; c2 = '0; rdr2 = 2'd0; rdc2 = 3'd2;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_turn", 64'(turn), 64'd1);
    checkOutput("rst_ready", 64'(move_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_count", 64'(move_count), 64'd0);
    checkOutput("rst_ack", 64'(move_ack), 64'd0);
    checkOutput("rst_err", 64'(move_err), 64'd0);
    checkOutput("rst2_turn", 64'(turn2), 64'd1);
    checkOutput("rst2_ready", 64'(ready2), 64'd1);
    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;

    $display("[TB] first move");
    applyStimulus(1'b1, 2'd1, 3'd2, 3'd3, 1'b0);
    @(posedge clk); #2;
    bf = board_flat;
    checkOutput("t1_ack", 64'(move_ack), 64'd1);
    checkOutput("t1_cell13", 64'(bf[27:26]), 64'd1);
    checkOutput("t1_turn", 64'(turn), 64'd2);
    checkOutput("t1_count", 64'(move_count), 64'd1);

    $display("[TB] rejected moves");
    applyStimulus(1'b1, 2'd2, 3'd2, 3'd3, 1'b0);
    @(posedge clk); #2;
    checkOutput("t2_occ_err", 64'(move_err), 64'd1);
    checkOutput("t2_occ_code", 64'(err_code), 64'd3);
    applyStimulus(1'b1, 2'd1, 3'd0, 3'd0, 1'b0);
    @(posedge clk); #2;
    checkOutput("t2_turn_code", 64'(err_code), 64'd2);
    applyStimulus(1'b1, 2'd2, 3'd5, 3'd0, 1'b0);
    @(posedge clk); #2;
    checkOutput("t2_range_code", 64'(err_code), 64'd1);
    applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
    @(posedge clk); #2;
    checkOutput("t2_board", 64'(board_flat), 64'h400_0000);
    checkOutput("t2_turn", 64'(turn), 64'd2);
    checkOutput("t2_err_drop", 64'(move_err), 64'd0);
    checkOutput("t2_code_drop", 64'(err_code), 64'd0);

    $display("[TB] clear with held move");
    applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 1'b1);
    @(posedge clk); #2;
    busy_cnt = busy ? 1 : 0;
    applyStimulus(1'b1, 2'd1, 3'd0, 3'd0, 1'b0);
    first_ack = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #2;
      if (busy) busy_cnt++;
      if (move_ack) begin
        first_ack = i;
        break;
      end
    end
    checkOutput("t4_ack_edge", 64'(first_ack), 64'd6);
    checkOutput("t4_busy_cycles", 64'(busy_cnt), 64'd5);
    checkOutput("t4_board", 64'(board_flat), 64'd1);

    $display("[TB] preempted move and repeated clear");
    applyStimulus(1'b1, 2'd2, 3'd1, 3'd1, 1'b1);
    @(posedge clk); #2;
    checkOutput("t5_err", 64'(move_err), 64'd1);
    checkOutput("t5_code", 64'(err_code), 64'd0);
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, (i == 2));
      @(posedge clk); #2;
      if (busy) busy_cnt++;
    end
    checkOutput("t5_busy_cycles", 64'(busy_cnt), 64'd5);
    checkOutput("t5_board", 64'(board_flat), 64'd0);

    $display("[TB] fill the board");
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("t3_rst_count", 64'(move_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1'b1, 2'((k % 2) + 1), 3'(k / 5), 3'(k % 5), 1'b0);
    end
    @(posedge clk); #2;
    checkOutput("t3_full", 64'(board_full), 64'd1);
    checkOutput("t3_count", 64'(move_count), 64'd25);
    applyStimulus(1'b1, 2'd2, 3'd0, 3'd0, 1'b0);
    @(posedge clk); #2;
    checkOutput("t3_extra_err", 64'(move_err), 64'd1);
    checkOutput("t3_extra_code", 64'(err_code), 64'd3);
    applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
    @(posedge clk); #2;

    $display("[TB] three-player 4x6 build");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v2 = 1'b1;
      p2 = 2'(mv2[i][0]);
      r2 = 2'(mv2[i][1]);
      c2 = 3'(mv2[i][2]);
      @(posedge clk); #2;
      checkOutput("d2_ack", 64'(ack2), 64'd1);
      checkOutput("d2_err", 64'(err2), 64'd0);
      checkOutput("d2_turn", 64'(turn2), 64'(exp_turn2[i]));
    end
    @(negedge clk);
    v2 = 1'b0;
    checkOutput("d2_board", 64'(flat2), 64'h8000_0000_1039);
    checkOutput("d2_count", 64'(count2), 64'd5);
    checkOutput("d2_rd_cell", 64'(rdcell2), 64'd3);
    checkOutput("d2_full", 64'(full2), 64'd0);
    checkOutput("d2_code", 64'(code2), 64'd0);
    clr2 = 1'b1;
    @(posedge clk); #2;
    checkOutput("d2_busy", 64'(busy2), 64'd1);
    checkOutput("d2_ready", 64'(ready2), 64'd0);
    @(negedge clk);
    clr2 = 1'b0;
    @(posedge clk); #2;
    checkOutput("d2_mid_sweep", 64'(flat2), 64'h8000_0000_1000);
    @(negedge clk);
    #1;
    rst2_n = 1'b0;
    #1;
    checkOutput("d2_rst_busy", 64'(busy2), 64'd0);
    checkOutput("d2_rst_turn", 64'(turn2), 64'd1);
    checkOutput("d2_rst_count", 64'(count2), 64'd0);
    checkOutput("d2_rst_board", 64'(flat2), 64'd0);
    checkOutput("d2_rst_ready", 64'(ready2), 64'd1);
    #1;
    rst2_n = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
